// File: rtl/ram32x8.sv
// Single-port 32x8 synchronous RAM with registered, write-through read data.
// Powers up holding the ascending odd sequence 1, 3, ..., 63 so it can be searched immediately.
module ram32x8 #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wren,
   output logic [DATA_WIDTH-1:0] q
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Power-up image: mem[i] = 2*i + 1. Reset never touches the array.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{
      8'd1,  8'd3,  8'd5,  8'd7,  8'd9,  8'd11, 8'd13, 8'd15,
      8'd17, 8'd19, 8'd21, 8'd23, 8'd25, 8'd27, 8'd29, 8'd31,
      8'd33, 8'd35, 8'd37, 8'd39, 8'd41, 8'd43, 8'd45, 8'd47,
      8'd49, 8'd51, 8'd53, 8'd55, 8'd57, 8'd59, 8'd61, 8'd63
   };

   logic [DATA_WIDTH-1:0] q_p1 = '0;

   // Stage p0 -> p1: reset beats wren; a write also forwards its data to q.
   always_ff @(posedge clock) begin
      if (reset) begin
         q_p1 <= '0;
      end else if (wren) begin
         mem[address] <= data;
         q_p1         <= data;
      end else begin
         q_p1 <= mem[address];
      end
   end

   assign q = q_p1;

endmodule

// File: tb/tb_ram32x8.sv
// Directed bench for ram32x8: vector table, latency/stability sequence,
// and a binary-search controller probing the power-up table.
module tb_ram32x8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] address = '0;
   logic [7:0] data = '0;
   logic       wren = 1'b0;
   logic [7:0] q;

   int n_total = 0;
   int n_pass  = 0;

   ram32x8 dut (
      .clock  (clock),
      .reset  (reset),
      .address(address),
      .data   (data),
      .wren   (wren),
      .q      (q)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic       we;
      logic [4:0] addr;
      logic [7:0] din;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs [47];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic apply(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
      reset   = r;
      wren    = w;
      address = a;
      data    = d;
      @(posedge clock);
      #1;
   endtask

   task automatic bsearch(input logic [7:0] key, output logic found, output int idx);
      int lo = 0;
      int hi = 31;
      int mid;
      found = 1'b0;
      idx   = -1;
      for (int it = 0; it < 6 && !found && lo <= hi; it++) begin
         mid = (lo + hi) / 2;
         apply(1'b0, 1'b0, 5'(mid), 8'h00);
         if (q == key) begin
            found = 1'b1;
            idx   = mid;
         end else if (q < key) begin
            lo = mid + 1;
         end else begin
            hi = mid - 1;
         end
      end
   endtask

   initial begin
      logic found;
      int   idx;

      vecs[0] = '{1'b1, 1'b0, 5'd0, 8'h00, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'd1};
      vecs[2] = '{1'b0, 1'b0, 5'd1,  8'h00, 8'd3};
      vecs[3] = '{1'b0, 1'b0, 5'd2,  8'h00, 8'd5};
      vecs[4] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'd7};
      vecs[5] = '{1'b0, 1'b0, 5'd4,  8'h00, 8'd9};
      vecs[6] = '{1'b0, 1'b0, 5'd5,  8'h00, 8'd11};
      vecs[7] = '{1'b0, 1'b0, 5'd6,  8'h00, 8'd13};
      vecs[8] = '{1'b0, 1'b0, 5'd7,  8'h00, 8'd15};
      vecs[9] = '{1'b0, 1'b0, 5'd8,  8'h00, 8'd17};
      vecs[10] = '{1'b0, 1'b0, 5'd9,  8'h00, 8'd19};
      vecs[11] = '{1'b0, 1'b0, 5'd10, 8'h00, 8'd21};
      vecs[12] = '{1'b0, 1'b0, 5'd11, 8'h00, 8'd23};
      vecs[13] = '{1'b0, 1'b0, 5'd12, 8'h00, 8'd25};
      vecs[14] = '{1'b0, 1'b0, 5'd13, 8'h00, 8'd27};
      vecs[15] = '{1'b0, 1'b0, 5'd14, 8'h00, 8'd29};
      vecs[16] = '{1'b0, 1'b0, 5'd15, 8'h00, 8'd31};
      vecs[17] = '{1'b0, 1'b0, 5'd16, 8'h00, 8'd33};
      vecs[18] = '{1'b0, 1'b0, 5'd17, 8'h00, 8'd35};
      vecs[19] = '{1'b0, 1'b0, 5'd18, 8'h00, 8'd37};
      vecs[20] = '{1'b0, 1'b0, 5'd19, 8'h00, 8'd39};
      vecs[21] = '{1'b0, 1'b0, 5'd20, 8'h00, 8'd41};
      vecs[22] = '{1'b0, 1'b0, 5'd21, 8'h00, 8'd43};
      vecs[23] = '{1'b0, 1'b0, 5'd22, 8'h00, 8'd45};
      vecs[24] = '{1'b0, 1'b0, 5'd23, 8'h00, 8'd47};
      vecs[25] = '{1'b0, 1'b0, 5'd24, 8'h00, 8'd49};
      vecs[26] = '{1'b0, 1'b0, 5'd25, 8'h00, 8'd51};
      vecs[27] = '{1'b0, 1'b0, 5'd26, 8'h00, 8'd53};
      vecs[28] = '{1'b0, 1'b0, 5'd27, 8'h00, 8'd55};
      vecs[29] = '{1'b0, 1'b0, 5'd28, 8'h00, 8'd57};
      vecs[30] = '{1'b0, 1'b0, 5'd29, 8'h00, 8'd59};
      vecs[31] = '{1'b0, 1'b0, 5'd30, 8'h00, 8'd61};
      vecs[32] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'd63};
      // write-through, readback, neighbour untouched
      vecs[33] = '{1'b0, 1'b1, 5'd7,  8'hA5, 8'hA5};
      vecs[34] = '{1'b0, 1'b0, 5'd7,  8'h00, 8'hA5};
      vecs[35] = '{1'b0, 1'b0, 5'd8,  8'h00, 8'd17};
      // reset outranks a write
      vecs[36] = '{1'b1, 1'b1, 5'd3,  8'hFF, 8'h00};
      vecs[37] = '{1'b0, 1'b0, 5'd3,  8'h00, 8'd7};
      // contents survive reset
      vecs[38] = '{1'b0, 1'b1, 5'd12, 8'h5A, 8'h5A};
      vecs[39] = '{1'b1, 1'b0, 5'd12, 8'h00, 8'h00};
      vecs[40] = '{1'b0, 1'b0, 5'd12, 8'h00, 8'h5A};
      // restore the ascending image for the search phase
      vecs[41] = '{1'b0, 1'b1, 5'd7,  8'd15, 8'd15};
      vecs[42] = '{1'b0, 1'b1, 5'd12, 8'd25, 8'd25};
      vecs[43] = '{1'b0, 1'b0, 5'd7,  8'h00, 8'd15};
      vecs[44] = '{1'b0, 1'b0, 5'd12, 8'h00, 8'd25};
      vecs[45] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'd63};
      vecs[46] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'd1};

      #1;
      check("q_before_first_edge", q, 8'h00);

      for (int i = 0; i < 47; i++) begin
         apply(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].din);
         check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), q, vecs[i].exp_q);
      end

      // one-cycle latency and hold between edges
      apply(1'b0, 1'b0, 5'd5, 8'h00);
      check("lat_edge_k", q, 8'd11);
      address = 5'd6;
      #3;
      check("lat_hold_mid_cycle", q, 8'd11);
      @(posedge clock);
      #1;
      check("lat_edge_k1", q, 8'd13);
      wren = 1'b1;
      data = 8'hEE;
      #2;
      check("hold_no_comb_path", q, 8'd13);
      wren = 1'b0;

      bsearch(8'd41, found, idx);
      check("search41_found", found, 1);
      check("search41_index", idx, 20);
      bsearch(8'd0, found, idx);
      check("search0_found", found, 0);
      bsearch(8'd63, found, idx);
      check("search63_found", found, 1);
      check("search63_index", idx, 31);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
